// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_ctrl
// Purpose  : Sequencer for an N-bit shift-add multiplier datapath.
// Revision : 1.0
// ============================================================================
module shift_add_mult_ctrl #(
    parameter int N    = 8,
    parameter int WD_W = $clog2(N + 3)
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic zero,
    input  logic q0,
    output logic load_operands,
    output logic clear_a,
    output logic load_counter,
    output logic shift_add,
    output logic adder_mux_select,
    output logic decr_counter,
    output logic ready,
    output logic done,
    output logic error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              error_q, error_d;

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        error_d = error_q;
        if (start && (state_q != S_IDLE)) begin
            error_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    error_d = 1'b0;
                end
            end
            S_LOAD: begin
                wd_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (zero) begin
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    // Counter never reached zero after N+1 shifts: abandon the product
                    if (wd_q == WD_W'(N)) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end

    logic run_active;
    assign run_active = (state_q == S_RUN) && !zero;

    assign load_operands    = (state_q == S_LOAD);
    assign clear_a          = (state_q == S_LOAD);
    assign load_counter     = (state_q == S_LOAD);
    assign shift_add        = run_active;
    assign decr_counter     = run_active;
    assign adder_mux_select = run_active && q0;
    assign ready            = (state_q == S_IDLE);
    assign done             = (state_q == S_DONE);
    assign error            = error_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mult_ctrl
// Purpose  : Directed bench for shift_add_mult_ctrl with a behavioural datapath.
// Revision : 1.0
// ============================================================================
module tb_shift_add_mult_ctrl;
    localparam int N = 8;

    logic clock = 1'b0;
    logic reset, start, zero, q0;
    logic load_operands, clear_a, load_counter, shift_add;
    logic adder_mux_select, decr_counter, ready, done, error;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_in, q_in;
    logic       stall;
    logic [7:0] dp_a, dp_m, dp_q;
    logic [3:0] dp_cnt;
    logic [8:0] sum;
    logic [6:0] strobes;

    shift_add_mult_ctrl #(.N(N)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .zero             (zero),
        .q0               (q0),
        .load_operands    (load_operands),
        .clear_a          (clear_a),
        .load_counter     (load_counter),
        .shift_add        (shift_add),
        .adder_mux_select (adder_mux_select),
        .decr_counter     (decr_counter),
        .ready            (ready),
        .done             (done),
        .error            (error)
    );

    always #5 clock = ~clock;

    assign sum = {1'b0, dp_a} + {1'b0, (adder_mux_select ? dp_m : 8'd0)};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dp_a   <= '0;
            dp_m   <= '0;
            dp_q   <= '0;
            dp_cnt <= '0;
        end else begin
            if (load_operands) begin
                dp_m <= m_in;
                dp_q <= q_in;
            end
            if (clear_a)      dp_a   <= '0;
            if (load_counter) dp_cnt <= 4'(N);
            if (shift_add) begin
                dp_a <= sum[8:1];
                dp_q <= {sum[0], dp_q[7:1]};
            end
            if (decr_counter) dp_cnt <= dp_cnt - 4'd1;
        end
    end

    assign zero    = stall ? 1'b0 : (dp_cnt == 4'd0);
    assign q0      = dp_q[0];
    assign strobes = {load_operands, clear_a, load_counter, shift_add, decr_counter, done, ready};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // Runs one multiply from IDLE; optionally pulses start during shift cycle 'inject'.
    task automatic do_mult(input logic [7:0] a, input logic [7:0] b, input int inject,
                           input logic exp_err);
        logic [15:0] prod;
        prod = 16'(a) * 16'(b);
        m_in = a;
        q_in = b;
        chk("idle_ready", 32'(ready), 32'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("load_strobes", 32'(strobes), 32'b1110000);
        chk("load_err_clear", 32'(error), 32'd0);
        for (int i = 0; i < N; i++) begin
            cyc();
            chk("shift_strobes", 32'(strobes), 32'b0001100);
            chk("adder_sel", 32'(adder_mux_select), 32'(b[i]));
            start = (i == inject);
        end
        cyc();
        start = 1'b0;
        chk("zero_cycle", 32'(strobes), 32'b0000000);
        cyc();
        chk("done_pulse", 32'(strobes), 32'b0000010);
        chk("product", 32'({dp_a, dp_q}), 32'(prod));
        chk("error_at_done", 32'(error), 32'(exp_err));
        cyc();
        chk("ready_back", 32'(strobes), 32'b0000001);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        m_in  = '0;
        q_in  = '0;

        #12 reset = 1'b0;
        #1;
        chk("reset_strobes", 32'(strobes), 32'b0000001);
        chk("reset_error", 32'(error), 32'd0);
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_quiet", 32'(strobes), 32'b0000001);
        end

        do_mult(8'd13, 8'd11, -1, 1'b0);
        do_mult(8'hFF, 8'hFF, -1, 1'b0);
        do_mult(8'hA5, 8'h00, -1, 1'b0);

        // Start during RUN is ignored but flagged; the next accepted start clears it.
        do_mult(8'd13, 8'd11, 2, 1'b1);
        chk("err_sticky_idle", 32'(error), 32'd1);
        do_mult(8'd3, 8'd4, -1, 1'b0);

        stall = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("stall_load", 32'(strobes), 32'b1110000);
        for (int i = 0; i < N + 1; i++) begin
            cyc();
            chk("stall_shift", 32'(strobes), 32'b0001100);
        end
        cyc();
        chk("stall_idle", 32'(strobes), 32'b0000001);
        chk("stall_error", 32'(error), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_no_done", 32'(strobes), 32'b0000001);
        end
        stall = 1'b0;

        m_in  = 8'd9;
        q_in  = 8'd6;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("run4_active", 32'(strobes), 32'b0001100);
        #1 reset = 1'b0;
        #1;
        chk("midrun_reset", 32'(strobes), 32'b0000001);
        chk("midrun_error", 32'(error), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_reset_idle", 32'(strobes), 32'b0000001);

        do_mult(8'd5, 8'd7, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
